// File: rtl/code_lock_ctrl_if.sv
// Signal bundle between the code-lock controller and its board-level surroundings.
// The slave side is the controller; the master side drives the key and comparator result.
interface code_lock_ctrl_if;
    logic       enter_n;
    logic       match;
    logic       unlocked;
    logic       lockout;
    logic [3:0] tries_left;
    logic [6:0] hex_status;
    logic [6:0] hex_tries;

    modport master (
        output enter_n,
        output match,
        input  unlocked,
        input  lockout,
        input  tries_left,
        input  hex_status,
        input  hex_tries
    );

    modport slave (
        input  enter_n,
        input  match,
        output unlocked,
        output lockout,
        output tries_left,
        output hex_status,
        output hex_tries
    );
endinterface

// File: rtl/code_lock_ctrl.sv
// Code-lock state machine: synchronizes the enter key and match result, counts failed
// attempts, and holds timed OPEN and LOCKOUT windows while driving two HEX displays.
module code_lock_ctrl #(
    parameter int MAX_TRIES      = 3,
    parameter int UNLOCK_CYCLES  = 250000000,
    parameter int LOCKOUT_CYCLES = 500000000
) (
    input logic             clk,
    input logic             reset_n,
    code_lock_ctrl_if.slave bus
);

    localparam int MAX_CYCLES = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [TW-1:0] UNLOCK_LAST  = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0] LOCKOUT_LAST = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [3:0]    TRIES_INIT   = 4'(MAX_TRIES);

    localparam logic [1:0] ST_ARMED   = 2'd0;
    localparam logic [1:0] ST_OPEN    = 2'd1;
    localparam logic [1:0] ST_LOCKOUT = 2'd2;

    localparam logic [6:0] GLYPH_L     = 7'b1000111;
    localparam logic [6:0] GLYPH_O     = 7'b1000000;
    localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    function automatic logic [6:0] digit(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = GLYPH_BLANK;
        endcase
        return seg;
    endfunction

    logic          r_enterSync1;
    logic          r_enterSync2;
    logic          r_enterPrev;
    logic          r_matchSync1;
    logic          r_matchSync2;
    logic          r_press;
    logic          r_pressMatch;
    logic          w_pressEdge;

    logic [1:0]    r_state;
    logic [3:0]    r_tries;
    logic [TW-1:0] r_timer;
    logic          r_unlocked;
    logic          r_lockout;
    logic [6:0]    r_hexStatus;
    logic [6:0]    r_hexTries;

    logic [1:0]    w_stateNext;
    logic [3:0]    w_triesNext;
    logic [TW-1:0] w_timerNext;
    logic [6:0]    w_hexStatusNext;
    logic [6:0]    w_hexTriesNext;

    assign w_pressEdge = r_enterPrev & ~r_enterSync2;

    // The press pulse is registered once more, so match is captured alongside it from
    // the same sample edge as the first low enter_n sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_enterSync1 <= 1'b1;
            r_enterSync2 <= 1'b1;
            r_enterPrev  <= 1'b1;
            r_matchSync1 <= 1'b0;
            r_matchSync2 <= 1'b0;
            r_press      <= 1'b0;
            r_pressMatch <= 1'b0;
        end else begin
            r_enterSync1 <= bus.enter_n;
            r_enterSync2 <= r_enterSync1;
            r_enterPrev  <= r_enterSync2;
            r_matchSync1 <= bus.match;
            r_matchSync2 <= r_matchSync1;
            r_press      <= w_pressEdge;
            r_pressMatch <= r_matchSync2;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_triesNext = r_tries;
        w_timerNext = r_timer;
        case (r_state)
            ST_ARMED: begin
                if (r_press) begin
                    if (r_pressMatch) begin
                        w_stateNext = ST_OPEN;
                        w_triesNext = TRIES_INIT;
                        w_timerNext = '0;
                    end else if (r_tries > 4'd1) begin
                        w_triesNext = r_tries - 4'd1;
                    end else begin
                        w_stateNext = ST_LOCKOUT;
                        w_triesNext = 4'd0;
                        w_timerNext = '0;
                    end
                end
            end
            ST_OPEN: begin
                if (r_timer == UNLOCK_LAST) begin
                    w_stateNext = ST_ARMED;
                    w_timerNext = '0;
                end else begin
                    w_timerNext = r_timer + 1'b1;
                end
            end
            ST_LOCKOUT: begin
                if (r_timer == LOCKOUT_LAST) begin
                    w_stateNext = ST_ARMED;
                    w_triesNext = TRIES_INIT;
                    w_timerNext = '0;
                end else begin
                    w_timerNext = r_timer + 1'b1;
                end
            end
            default: begin
                w_stateNext = ST_ARMED;
                w_triesNext = TRIES_INIT;
                w_timerNext = '0;
            end
        endcase
    end

    // Display glyphs are decoded from the next state so they change on the same edge.
    always_comb begin
        w_hexStatusNext = GLYPH_L;
        w_hexTriesNext  = digit(w_triesNext);
        case (w_stateNext)
            ST_OPEN: begin
                w_hexStatusNext = GLYPH_O;
                w_hexTriesNext  = GLYPH_BLANK;
            end
            ST_LOCKOUT: begin
                w_hexStatusNext = GLYPH_DASH;
            end
            default: begin
                w_hexStatusNext = GLYPH_L;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_ARMED;
            r_tries     <= TRIES_INIT;
            r_timer     <= '0;
            r_unlocked  <= 1'b0;
            r_lockout   <= 1'b0;
            r_hexStatus <= GLYPH_L;
            r_hexTries  <= digit(TRIES_INIT);
        end else begin
            r_state     <= w_stateNext;
            r_tries     <= w_triesNext;
            r_timer     <= w_timerNext;
            r_unlocked  <= (w_stateNext == ST_OPEN);
            r_lockout   <= (w_stateNext == ST_LOCKOUT);
            r_hexStatus <= w_hexStatusNext;
            r_hexTries  <= w_hexTriesNext;
        end
    end

    assign bus.unlocked   = r_unlocked;
    assign bus.lockout    = r_lockout;
    assign bus.tries_left = r_tries;
    assign bus.hex_status = r_hexStatus;
    assign bus.hex_tries  = r_hexTries;

endmodule

// File: doc/code_lock_ctrl.md
Name: code_lock_ctrl

Overview:
- Downstream consumer of the switch-code comparator. Takes its 1-bit match result and a raw push-button "enter" key, and runs a code-lock state machine.
- Features: attempt counting, a timed unlock window and a timed lockout after too many failures.
- Drives two DE1-SoC HEX displays (status letter, tries remaining) plus status LEDs.

Parameters:
- MAX_TRIES, 3, wrong entries allowed before lockout; legal range 1..9.
- UNLOCK_CYCLES, 250000000, clock cycles spent in OPEN (5 s at 50 MHz); bench overrides to 6.
- LOCKOUT_CYCLES, 500000000, clock cycles spent in LOCKOUT (10 s at 50 MHz); bench overrides to 10.

Ports:
- clk  input  1  system clock, 50 MHz on board.
- reset_n  input  1  asynchronous, active-low reset.
- enter_n  input  1  raw KEY, active-low, asynchronous to clk, assumed debounced by hardware.
- match  input  1  comparator result, 1 = switches equal stored code; asynchronous (switch-derived).
- unlocked  output  1  high while in OPEN.
- lockout  output  1  high while in LOCKOUT.
- tries_left  output  4  remaining attempts, 0..MAX_TRIES.
- hex_status  output  7  status glyph, active-low, bit order {g,f,e,d,c,b,a}.
- hex_tries  output  7  tries_left digit, same encoding.

Behaviour:
- One clock domain. Reset is asynchronous and active-low; all flops clear immediately on reset_n low, including mid-timer.
- Reset values:
  - state = ARMED, tries_left = MAX_TRIES, unlocked = 0, lockout = 0, timer = 0.
  - enter synchronizer flops = 1; match synchronizer flops = 0.
  - hex_status = 7'b1000111 ('L'); hex_tries = digit(MAX_TRIES).
- Input conditioning:
  - enter_n and match each pass through a 2-flop synchronizer.
  - A press pulse is a 1-cycle high on the 1->0 transition of synchronized enter_n, using a third registered copy for edge detect.
  - Holding the key produces exactly one pulse. Release produces none.
- Latency:
  - enter_n first sampled low at clock edge k -> press pulse high between edges k+2 and k+3 -> state/outputs updated at edge k+3.
  - The match value used is the synchronized value at the pulse cycle, i.e. the match value sampled at edge k.
- States:
  - ARMED:
    - press & match -> OPEN; tries_left <= MAX_TRIES; timer <= 0.
    - press & !match & tries_left > 1 -> stay in ARMED; tries_left decrements by 1.
    - press & !match & tries_left == 1 -> LOCKOUT; tries_left <= 0; timer <= 0.
  - OPEN:
    - timer increments each cycle.
    - When timer == UNLOCK_CYCLES-1 -> ARMED; timer <= 0.
    - unlocked is high for exactly UNLOCK_CYCLES cycles.
  - LOCKOUT:
    - Same timing, using LOCKOUT_CYCLES.
    - Exit to ARMED with tries_left <= MAX_TRIES.
    - lockout is high for exactly LOCKOUT_CYCLES cycles.
- Press pulses in OPEN or LOCKOUT are ignored: no state or counter change, and they are not queued.
- A press pulse coinciding with the terminal timer cycle is ignored. The transition to ARMED takes priority, and the next press is evaluated in ARMED.
- unlocked and lockout are never both high.
- Timer width = clog2(max(UNLOCK_CYCLES, LOCKOUT_CYCLES)); no wrap-around is possible.
- tries_left never underflows below 0 and never exceeds MAX_TRIES.
- Displays (registered Moore outputs, derived from state and tries_left):
  - hex_status: ARMED = 'L' 7'b1000111; OPEN = 'O' 7'b1000000; LOCKOUT = '-' 7'b0111111.
  - hex_tries = digit(tries_left) in ARMED and LOCKOUT; blank 7'b1111111 in OPEN.
  - Digit encodings:
    - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
    - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000

Test Plan (MAX_TRIES = 3, UNLOCK_CYCLES = 6, LOCKOUT_CYCLES = 10):
1. Reset release, no press -> tries_left = 3, hex_status = 1000111, hex_tries = 0110000, unlocked = 0, lockout = 0.
2. match = 1, enter_n pulsed low for 4 cycles -> unlocked rises 3 edges after first low sample and stays high exactly 6 cycles. Single entry despite hold. hex_tries = 1111111 while open. Returns to ARMED with tries_left = 3.
3. match = 0, three separate presses -> tries_left goes 2, 1, 0. After the third, lockout = 1 for exactly 10 cycles, hex_status = 0111111. Then ARMED with tries_left = 3.
4. During LOCKOUT, match = 1 and press -> no unlock, timer unaffected. During OPEN, press -> unlocked duration still exactly 6.
5. Two wrong entries (tries_left = 1), then match = 1 press -> OPEN, and tries_left restores to 3 on entry.
6. reset_n asserted mid-OPEN (cycle 3) and mid-LOCKOUT -> outputs return immediately (asynchronously) to reset values. After release, first press is evaluated normally.
